// File: rtl/cpu7_ifu_fcl.sv
// Fetch control for the IFU. Owns the fetch PC and issues one instruction
// request per accepted handshake. It remembers the PC of every in-flight
// request, discards responses made stale by a branch cancel, and queues
// fetched instructions toward decode.
//
// state  | meaning
// -------+--------------------------------------------------------------
// INIT   | first cycle after reset; fetch_pc loads pc_init, no requests
// RUN    | normal fetch; requests issued while credit allows
// EXWAIT | exception instruction buffered; no requests until br_cancel
module cpu7_ifu_fcl #(
  parameter int DEPTH = 4,
  parameter int PCW   = 32
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [PCW-1:0] pc_init,
  input  logic           br_cancel,
  input  logic [PCW-1:0] br_target,
  output logic           inst_req,
  output logic [31:0]    inst_addr,
  input  logic           inst_addr_ok,
  output logic           inst_cancel,
  input  logic           inst_valid,
  input  logic [127:0]   inst_rdata,
  input  logic           inst_ex,
  input  logic [5:0]     inst_exccode,
  output logic           fcl_dec_valid,
  input  logic           fcl_dec_ready,
  output logic [PCW-1:0] fcl_dec_pc,
  output logic [31:0]    fcl_dec_inst,
  output logic           fcl_dec_ex,
  output logic [5:0]     fcl_dec_exccode
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_RUN    = 2'd1,
    S_EXWAIT = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [PCW-1:0] fetch_pc;

  // PC of each in-flight request, oldest at pcq_rd
  logic [PCW-1:0] pcq [DEPTH];
  logic [AW-1:0]  pcq_wr, pcq_rd;

  logic [CW-1:0]  outstanding;
  logic [CW-1:0]  discard;

  // Decode-side instruction buffer
  logic [PCW-1:0] buf_pc   [DEPTH];
  logic [31:0]    buf_inst [DEPTH];
  logic           buf_ex   [DEPTH];
  logic [5:0]     buf_exc  [DEPTH];
  logic [AW-1:0]  buf_head, buf_tail;
  logic [CW-1:0]  buf_count;

  logic [CW:0]    credit_sum;
  logic           credit_ok;
  logic           accept;
  logic [PCW-1:0] resp_pc;
  logic [1:0]     resp_lane;
  logic [31:0]    resp_word;
  logic           resp_keep;
  logic           dec_pop;

  // Credit covers both in-flight requests and instructions still buffered,
  // so every response is guaranteed a buffer slot.
  always_comb begin
    credit_sum = {1'b0, outstanding} + {1'b0, buf_count};
    credit_ok  = (credit_sum < (CW+1)'(DEPTH));
    resp_pc    = pcq[pcq_rd];
    resp_lane  = resp_pc[3:2];
    resp_word  = inst_rdata[{resp_lane, 5'b00000} +: 32];
    resp_keep  = inst_valid & ~br_cancel & (discard == '0);
    dec_pop    = fcl_dec_valid & fcl_dec_ready & ~br_cancel;
  end

  assign accept      = inst_req & inst_addr_ok;
  assign inst_cancel = br_cancel;
  assign inst_addr   = 32'(fetch_pc);

  // Head of the buffer is presented directly; data forced to zero when empty
  always_comb begin
    fcl_dec_valid   = (buf_count != '0);
    fcl_dec_pc      = '0;
    fcl_dec_inst    = '0;
    fcl_dec_ex      = 1'b0;
    fcl_dec_exccode = '0;
    if (fcl_dec_valid) begin
      fcl_dec_pc      = buf_pc[buf_head];
      fcl_dec_inst    = buf_inst[buf_head];
      fcl_dec_ex      = buf_ex[buf_head];
      fcl_dec_exccode = buf_exc[buf_head];
    end
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_INIT;
    else       state <= state_nxt;
  end

  // Next-state and request generation
  always_comb begin
    state_nxt = state;
    inst_req  = 1'b0;
    unique case (state)
      S_INIT: begin
        state_nxt = S_RUN;
      end
      S_RUN: begin
        inst_req = ~br_cancel & credit_ok;
        if (!br_cancel && resp_keep && inst_ex) state_nxt = S_EXWAIT;
      end
      S_EXWAIT: begin
        if (br_cancel) state_nxt = S_RUN;
      end
      default: state_nxt = S_INIT;
    endcase
  end

  // Fetch PC: load on init, redirect on cancel, step on each accepted request
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                fetch_pc <= '0;
    else if (state == S_INIT) fetch_pc <= pc_init;
    else if (br_cancel)       fetch_pc <= br_target;
    else if (accept)          fetch_pc <= fetch_pc + PCW'(4);
  end

  // PC queue storage; contents are only meaningful between the pointers
  always_ff @(posedge clock) begin
    if (accept) pcq[pcq_wr] <= fetch_pc;
  end

  // In-flight tracking: PC queue pointers, outstanding count, discard count
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pcq_wr      <= '0;
      pcq_rd      <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      if (accept)     pcq_wr <= pcq_wr + AW'(1);
      if (inst_valid) pcq_rd <= pcq_rd + AW'(1);
      unique case ({accept, inst_valid})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
      // A response arriving with the cancel is already dropped, so it is
      // not counted again among the responses still to discard.
      if (br_cancel)                        discard <= outstanding - CW'(inst_valid);
      else if (inst_valid && discard != '0) discard <= discard - CW'(1);
    end
  end

  // Buffer storage; the lane is chosen by the request PC
  always_ff @(posedge clock) begin
    if (resp_keep) begin
      buf_pc[buf_tail]   <= resp_pc;
      buf_inst[buf_tail] <= resp_word;
      buf_ex[buf_tail]   <= inst_ex;
      buf_exc[buf_tail]  <= inst_exccode;
    end
  end

  // Buffer pointers and occupancy; cancel flushes and wins over a pop
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      buf_head  <= '0;
      buf_tail  <= '0;
      buf_count <= '0;
    end else if (br_cancel) begin
      buf_head  <= '0;
      buf_tail  <= '0;
      buf_count <= '0;
    end else begin
      if (resp_keep) buf_tail <= buf_tail + AW'(1);
      if (dec_pop)   buf_head <= buf_head + AW'(1);
      unique case ({resp_keep, dec_pop})
        2'b10:   buf_count <= buf_count + CW'(1);
        2'b01:   buf_count <= buf_count - CW'(1);
        default: buf_count <= buf_count;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu7_ifu_fcl.sv
// Directed bench for cpu7_ifu_fcl: a simple in-order cache model answers
// accepted requests no earlier than the next cycle; expected PCs and words
// are worked out by hand from the stimulus.
module tb_cpu7_ifu_fcl;

  logic         clock;
  logic         reset;
  logic [31:0]  pc_init;
  logic         br_cancel;
  logic [31:0]  br_target;
  logic         inst_req;
  logic [31:0]  inst_addr;
  logic         inst_addr_ok;
  logic         inst_cancel;
  logic         inst_valid;
  logic [127:0] inst_rdata;
  logic         inst_ex;
  logic [5:0]   inst_exccode;
  logic         fcl_dec_valid;
  logic         fcl_dec_ready;
  logic [31:0]  fcl_dec_pc;
  logic [31:0]  fcl_dec_inst;
  logic         fcl_dec_ex;
  logic [5:0]   fcl_dec_exccode;

  cpu7_ifu_fcl #(.DEPTH(4), .PCW(32)) dut (
    .clock           (clock),
    .reset           (reset),
    .pc_init         (pc_init),
    .br_cancel       (br_cancel),
    .br_target       (br_target),
    .inst_req        (inst_req),
    .inst_addr       (inst_addr),
    .inst_addr_ok    (inst_addr_ok),
    .inst_cancel     (inst_cancel),
    .inst_valid      (inst_valid),
    .inst_rdata      (inst_rdata),
    .inst_ex         (inst_ex),
    .inst_exccode    (inst_exccode),
    .fcl_dec_valid   (fcl_dec_valid),
    .fcl_dec_ready   (fcl_dec_ready),
    .fcl_dec_pc      (fcl_dec_pc),
    .fcl_dec_inst    (fcl_dec_inst),
    .fcl_dec_ex      (fcl_dec_ex),
    .fcl_dec_exccode (fcl_dec_exccode)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  logic [31:0] pend  [$];
  logic [31:0] iss_q [$];
  logic [31:0] dpc_q [$];
  logic [31:0] dins_q[$];
  logic        dex_q [$];
  logic        resp_en;
  logic        ex_next;
  logic [5:0]  ex_code;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [127:0] line_of(input logic [31:0] a);
    logic [127:0] l;
    logic [31:0]  wa;
    for (int k = 0; k < 4; k++) begin
      wa = {a[31:4], 4'b0000} | (32'(k) << 2);
      l[32*k +: 32] = word_of(wa);
    end
    return l;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive the cache response, sample handshakes, advance.
  task automatic tick();
    logic        acc;
    logic [31:0] acc_addr;
    logic        hs;
    logic [31:0] hs_pc, hs_inst;
    logic        hs_ex;
    logic [31:0] ra;
    inst_valid = resp_en && (pend.size() != 0);
    if (inst_valid) begin
      ra           = pend[0];
      inst_rdata   = line_of(ra);
      inst_ex      = ex_next;
      inst_exccode = ex_next ? ex_code : 6'd0;
    end else begin
      inst_rdata   = '0;
      inst_ex      = 1'b0;
      inst_exccode = '0;
    end
    #1;
    acc      = inst_req && inst_addr_ok;
    acc_addr = inst_addr;
    hs       = fcl_dec_valid && fcl_dec_ready && !br_cancel;
    hs_pc    = fcl_dec_pc;
    hs_inst  = fcl_dec_inst;
    hs_ex    = fcl_dec_ex;
    @(posedge clock);
    if (inst_valid) begin
      void'(pend.pop_front());
      ex_next = 1'b0;
    end
    if (acc) begin
      pend.push_back(acc_addr);
      iss_q.push_back(acc_addr);
    end
    if (hs) begin
      dpc_q.push_back(hs_pc);
      dins_q.push_back(hs_inst);
      dex_q.push_back(hs_ex);
    end
    #1;
    inst_valid   = 1'b0;
    inst_rdata   = '0;
    inst_ex      = 1'b0;
    inst_exccode = '0;
  endtask

  task automatic clear_logs();
    iss_q.delete();
    dpc_q.delete();
    dins_q.delete();
    dex_q.delete();
  endtask

  initial begin
    reset = 1'b1; pc_init = 32'h1c00_0000; br_cancel = 1'b0; br_target = '0;
    inst_addr_ok = 1'b0; inst_valid = 1'b0; inst_rdata = '0; inst_ex = 1'b0;
    inst_exccode = '0; fcl_dec_ready = 1'b0; resp_en = 1'b0; ex_next = 1'b0; ex_code = '0;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check("rst_req",     64'(inst_req), 64'd0);
    check("rst_dvalid",  64'(fcl_dec_valid), 64'd0);
    check("rst_dpc",     64'(fcl_dec_pc), 64'd0);
    check("rst_dinst",   64'(fcl_dec_inst), 64'd0);
    check("rst_dex",     64'(fcl_dec_ex), 64'd0);
    check("rst_dexc",    64'(fcl_dec_exccode), 64'd0);

    // Test 1: streaming fetch, one instruction per cycle
    reset = 1'b0; inst_addr_ok = 1'b1; fcl_dec_ready = 1'b1; resp_en = 1'b1;
    #1;
    check("init_req", 64'(inst_req), 64'd0);
    tick();
    repeat (10) tick();
    check("t1_iss_cnt", 64'(iss_q.size()), 64'd10);
    check("t1_dec_cnt", 64'(dpc_q.size()), 64'd8);
    for (int i = 0; i < 4; i++) begin
      check("t1_addr", 64'(iss_q[i]), 64'(32'h1c00_0000 + 32'(4*i)));
      check("t1_dpc",  64'(dpc_q[i]), 64'(32'h1c00_0000 + 32'(4*i)));
      check("t1_dins", 64'(dins_q[i]), 64'(word_of(32'h1c00_0000 + 32'(4*i))));
    end
    inst_addr_ok = 1'b0;
    repeat (4) tick();
    clear_logs();

    // Test 2: decode stalled, credit limits issue to DEPTH
    fcl_dec_ready = 1'b0; inst_addr_ok = 1'b1;
    repeat (8) tick();
    check("t2_iss_cnt", 64'(iss_q.size()), 64'd4);
    check("t2_iss_last", 64'(iss_q[3]), 64'h1c00_0034);
    check("t2_req_full", 64'(inst_req), 64'd0);
    check("t2_dvalid", 64'(fcl_dec_valid), 64'd1);
    check("t2_dpc_head", 64'(fcl_dec_pc), 64'h1c00_0028);
    fcl_dec_ready = 1'b1;
    tick();
    check("t2_req_after_pop", 64'(inst_req), 64'd1);
    check("t2_addr_after_pop", 64'(inst_addr), 64'h1c00_0038);
    inst_addr_ok = 1'b0;
    repeat (5) tick();
    check("t2_dec_cnt", 64'(dpc_q.size()), 64'd4);
    check("t2_dpc_last", 64'(dpc_q[3]), 64'h1c00_0034);
    clear_logs();

    // Test 3: cancel with three requests in flight
    resp_en = 1'b0; inst_addr_ok = 1'b1; fcl_dec_ready = 1'b1;
    repeat (3) tick();
    br_cancel = 1'b1; br_target = 32'h1c00_0100;
    #1;
    check("t3_cancel_out", 64'(inst_cancel), 64'd1);
    check("t3_req_masked", 64'(inst_req), 64'd0);
    tick();
    br_cancel = 1'b0; resp_en = 1'b1;
    clear_logs();
    repeat (8) tick();
    check("t3_first_addr", 64'(iss_q[0]), 64'h1c00_0100);
    check("t3_first_dpc",  64'(dpc_q[0]), 64'h1c00_0100);
    check("t3_first_dins", 64'(dins_q[0]), 64'(word_of(32'h1c00_0100)));
    check("t3_second_dpc", 64'(dpc_q[1]), 64'h1c00_0104);
    inst_addr_ok = 1'b0;
    repeat (6) tick();
    clear_logs();

    // Test 4: cancel coincident with a response, two in flight, one buffered
    fcl_dec_ready = 1'b0; resp_en = 1'b1; inst_addr_ok = 1'b1;
    repeat (2) tick();
    resp_en = 1'b0;
    tick();
    check("t4_buffered", 64'(fcl_dec_valid), 64'd1);
    br_cancel = 1'b1; br_target = 32'h1c00_0200; resp_en = 1'b1; fcl_dec_ready = 1'b1;
    tick();
    br_cancel = 1'b0;
    #1;
    check("t4_flushed", 64'(fcl_dec_valid), 64'd0);
    clear_logs();
    repeat (6) tick();
    check("t4_first_dpc",  64'(dpc_q[0]), 64'h1c00_0200);
    check("t4_second_dpc", 64'(dpc_q[1]), 64'h1c00_0204);
    inst_addr_ok = 1'b0;
    repeat (8) tick();

    // Test 5: exception response stops fetch until redirect
    br_cancel = 1'b1; br_target = 32'h1c00_0300;
    tick();
    br_cancel = 1'b0;
    clear_logs();
    ex_next = 1'b1; ex_code = 6'h08; fcl_dec_ready = 1'b0; inst_addr_ok = 1'b1; resp_en = 1'b1;
    repeat (5) tick();
    check("t5_iss_cnt", 64'(iss_q.size()), 64'd2);
    check("t5_req_held", 64'(inst_req), 64'd0);
    check("t5_dpc",  64'(fcl_dec_pc), 64'h1c00_0300);
    check("t5_dins", 64'(fcl_dec_inst), 64'(word_of(32'h1c00_0300)));
    check("t5_dex",  64'(fcl_dec_ex), 64'd1);
    check("t5_dexc", 64'(fcl_dec_exccode), 64'h08);
    fcl_dec_ready = 1'b1;
    repeat (3) tick();
    check("t5_second_noex", 64'(dex_q[1]), 64'd0);
    check("t5_req_still_held", 64'(inst_req), 64'd0);
    br_cancel = 1'b1; br_target = 32'h1c00_0400;
    tick();
    br_cancel = 1'b0;
    #1;
    check("t5_resume_req",  64'(inst_req), 64'd1);
    check("t5_resume_addr", 64'(inst_addr), 64'h1c00_0400);

    // Test 6: reset with two in flight and two buffered
    clear_logs();
    fcl_dec_ready = 1'b0; resp_en = 1'b1;
    repeat (3) tick();
    resp_en = 1'b0;
    tick();
    check("t6_pre_valid", 64'(fcl_dec_valid), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_req",    64'(inst_req), 64'd0);
    check("t6_dvalid", 64'(fcl_dec_valid), 64'd0);
    check("t6_dpc",    64'(fcl_dec_pc), 64'd0);
    check("t6_dinst",  64'(fcl_dec_inst), 64'd0);
    check("t6_dex",    64'(fcl_dec_ex), 64'd0);
    pend.delete();
    pc_init = 32'h1c00_1000;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    check("t6_init_req", 64'(inst_req), 64'd0);
    resp_en = 1'b1; fcl_dec_ready = 1'b1;
    tick();
    check("t6_first_req",  64'(inst_req), 64'd1);
    check("t6_first_addr", 64'(inst_addr), 64'h1c00_1000);
    check("t6_no_stale",   64'(fcl_dec_valid), 64'd0);
    clear_logs();
    repeat (3) tick();
    check("t6_first_dpc", 64'(dpc_q[0]), 64'h1c00_1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
